// File: rtl/shift_pkg.sv
// Shared constants for the shared-shifter arbiter: op codes, requester ids
// and the result-register occupancy states.
package shift_pkg;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  localparam logic REQ_EX  = 1'b0;
  localparam logic REQ_AUX = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } res_state_e;

endpackage

// File: rtl/shift_arbiter_if.sv
// Request, result and status bundle between the two shift requesters,
// the arbiter and the writeback consumer.
interface shift_arbiter_if #(
  parameter int N = 32
);
  logic         req0_valid_i;
  logic         req0_ready_o;
  logic [N-1:0] req0_a_i;
  logic [N-1:0] req0_b_i;
  logic [1:0]   req0_ope_i;

  logic         req1_valid_i;
  logic         req1_ready_o;
  logic [N-1:0] req1_a_i;
  logic [N-1:0] req1_b_i;
  logic [1:0]   req1_ope_i;

  logic         res_valid_o;
  logic         res_ready_i;
  logic [N-1:0] res_data_o;
  logic         res_id_o;
  logic         busy_o;

  modport master (
    output req0_valid_i, req0_a_i, req0_b_i, req0_ope_i,
    output req1_valid_i, req1_a_i, req1_b_i, req1_ope_i,
    output res_ready_i,
    input  req0_ready_o, req1_ready_o,
    input  res_valid_o, res_data_o, res_id_o, busy_o
  );

  modport slave (
    input  req0_valid_i, req0_a_i, req0_b_i, req0_ope_i,
    input  req1_valid_i, req1_a_i, req1_b_i, req1_ope_i,
    input  res_ready_i,
    output req0_ready_o, req1_ready_o,
    output res_valid_o, res_data_o, res_id_o, busy_o
  );
endinterface

// File: rtl/shift_arbiter_shift.sv
// Combinational barrel shifter: SLL / SRL / SRA, reserved op yields zero.
module shift
  import shift_pkg::*;
#(
  parameter int N   = 32,
  parameter int SHW = $clog2(N)
) (
  input  logic [N-1:0]   a,
  input  logic [SHW-1:0] b,
  input  logic [1:0]     ope,
  output logic [N-1:0]   y
);

  logic signed [N-1:0] a_s;

  assign a_s = $signed(a);

  always_comb begin
    y = '0;
    case (ope)
      OP_SLL:  y = a << b;
      OP_SRL:  y = a >> b;
      OP_SRA:  y = $unsigned(a_s >>> b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one barrel shifter between the execute stage
// and the auxiliary unit, with a registered, tagged, back-pressured result.
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int N   = 32,
  parameter int SHW = $clog2(N)
) (
  input logic           clk_i,
  input logic           rst_i,
  shift_arbiter_if.slave bus
);

  res_state_e     state_p1;
  res_state_e     state_nxt;
  logic           rr_ptr;
  logic           can_accept;
  logic           gnt0;
  logic           gnt1;
  logic           gnt_any;
  logic           gnt_id;
  logic [N-1:0]   sh_a;
  logic [N-1:0]   sh_b_full;
  logic [SHW-1:0] sh_b;
  logic [1:0]     sh_ope;
  logic [N-1:0]   sh_y;
  logic [N-1:0]   res_data_p1;
  logic           res_id_p1;
  logic           vld_p1;
  logic           unused_b_hi;

  assign vld_p1     = (state_p1 == ST_FULL);
  assign can_accept = !vld_p1 || bus.res_ready_i;

  // Grant and occupancy next-state; reset masks grants so no ready leaks out.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    state_nxt = state_p1;
    if (!rst_i && can_accept) begin
      if (bus.req0_valid_i && bus.req1_valid_i) begin
        if (rr_ptr == REQ_EX) gnt0 = 1'b1;
        else                  gnt1 = 1'b1;
      end else if (bus.req0_valid_i) begin
        gnt0 = 1'b1;
      end else if (bus.req1_valid_i) begin
        gnt1 = 1'b1;
      end
    end
    if (gnt0 || gnt1) begin
      state_nxt = ST_FULL;
    end else if (vld_p1 && bus.res_ready_i) begin
      state_nxt = ST_EMPTY;
    end
  end

  assign gnt_any = gnt0 || gnt1;
  assign gnt_id  = gnt1 ? REQ_AUX : REQ_EX;

  assign sh_a      = gnt1 ? bus.req1_a_i   : bus.req0_a_i;
  assign sh_b_full = gnt1 ? bus.req1_b_i   : bus.req0_b_i;
  assign sh_ope    = gnt1 ? bus.req1_ope_i : bus.req0_ope_i;
  // Only the low SHW bits of the amount matter (RISC-V shamt semantics).
  assign sh_b        = sh_b_full[SHW-1:0];
  assign unused_b_hi = ^sh_b_full[N-1:SHW];

  shift #(
    .N   (N),
    .SHW (SHW)
  ) u_shift (
    .a   (sh_a),
    .b   (sh_b),
    .ope (sh_ope),
    .y   (sh_y)
  );

  // Stage p1: result register, tag and round-robin pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_p1    <= ST_EMPTY;
      rr_ptr      <= REQ_EX;
      res_data_p1 <= '0;
      res_id_p1   <= REQ_EX;
    end else begin
      state_p1 <= state_nxt;
      if (gnt_any) begin
        res_data_p1 <= sh_y;
        res_id_p1   <= gnt_id;
        rr_ptr      <= ~gnt_id;
      end
    end
  end

  assign bus.req0_ready_o = gnt0;
  assign bus.req1_ready_o = gnt1;
  assign bus.res_valid_o  = vld_p1;
  assign bus.res_data_o   = res_data_p1;
  assign bus.res_id_o     = res_id_p1;
  assign bus.busy_o       = vld_p1 && !bus.res_ready_i;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: expected results are queued as requests
// are issued and a negedge monitor checks each result as it is consumed.
module tb_shift_arbiter;
  import shift_pkg::*;

  localparam int N = 32;

  typedef struct packed {
    logic [N-1:0] data;
    logic         id;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  shift_arbiter_if #(.N(N)) bus ();

  shift_arbiter #(.N(N)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [N-1:0] data, input logic id);
    exp_t e;
    e.data = data;
    e.id   = id;
    sb.push_back(e);
  endtask

  // Every consumed result must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.res_valid_o && bus.res_ready_i) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got 0x%08h id %b want none", bus.res_data_o, bus.res_id_o);
      end else begin
        e = sb.pop_front();
        chk("sb_data", bus.res_data_o, e.data);
        chk1("sb_id", bus.res_id_o, e.id);
      end
    end
  end

  initial begin
    bus.req0_valid_i = 1'b1;
    bus.req0_a_i     = 32'h0000_00F0;
    bus.req0_b_i     = 32'd4;
    bus.req0_ope_i   = OP_SLL;
    bus.req1_valid_i = 1'b0;
    bus.req1_a_i     = '0;
    bus.req1_b_i     = '0;
    bus.req1_ope_i   = OP_SLL;
    bus.res_ready_i  = 1'b1;

    // Reset state, with a request pending that must stay masked.
    @(negedge clk);
    chk1("rst_valid", bus.res_valid_o, 1'b0);
    chk("rst_data", bus.res_data_o, 32'h0);
    chk1("rst_id", bus.res_id_o, 1'b0);
    chk1("rst_busy", bus.busy_o, 1'b0);
    chk1("rst_ready0", bus.req0_ready_o, 1'b0);

    // Single request from requester 0.
    step();
    rst = 1'b0;
    push(32'h0000_0F00, REQ_EX);
    @(negedge clk);
    chk1("t1_ready0", bus.req0_ready_o, 1'b1);
    chk1("t1_ready1", bus.req1_ready_o, 1'b0);
    step();
    bus.req0_valid_i = 1'b0;
    @(negedge clk);
    chk1("t1_ready0_low", bus.req0_ready_o, 1'b0);
    chk1("t1_valid", bus.res_valid_o, 1'b1);
    chk("t1_data", bus.res_data_o, 32'h0000_0F00);
    chk1("t1_id", bus.res_id_o, 1'b0);
    step();
    @(negedge clk);
    chk1("t1_drained", bus.res_valid_o, 1'b0);

    // Both continuously valid: grants alternate starting with requester 0.
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.req0_valid_i = 1'b1;
    bus.req0_a_i     = 32'h8000_0000;
    bus.req0_b_i     = 32'd31;
    bus.req0_ope_i   = OP_SRA;
    bus.req1_valid_i = 1'b1;
    bus.req1_a_i     = 32'h8000_0000;
    bus.req1_b_i     = 32'd31;
    bus.req1_ope_i   = OP_SRL;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) push(32'hFFFF_FFFF, REQ_EX);
      else            push(32'h0000_0001, REQ_AUX);
      @(negedge clk);
      chk1("rr_ready0", bus.req0_ready_o, (i % 2 == 0));
      chk1("rr_ready1", bus.req1_ready_o, (i % 2 == 1));
      step();
    end
    bus.req0_valid_i = 1'b0;
    bus.req1_valid_i = 1'b0;
    @(negedge clk);
    step();

    // Backpressure: result held, requester 1 waits, then same-cycle handoff.
    bus.res_ready_i  = 1'b0;
    bus.req0_valid_i = 1'b1;
    bus.req0_a_i     = 32'h1234_5678;
    bus.req0_b_i     = 32'd8;
    bus.req0_ope_i   = OP_SRL;
    push(32'h0012_3456, REQ_EX);
    @(negedge clk);
    chk1("bp_ready0_first", bus.req0_ready_o, 1'b1);
    step();
    bus.req0_valid_i = 1'b0;
    bus.req1_valid_i = 1'b1;
    bus.req1_a_i     = 32'h0000_000F;
    bus.req1_b_i     = 32'd36;
    bus.req1_ope_i   = OP_SLL;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("bp_valid", bus.res_valid_o, 1'b1);
      chk1("bp_busy", bus.busy_o, 1'b1);
      chk1("bp_ready0", bus.req0_ready_o, 1'b0);
      chk1("bp_ready1", bus.req1_ready_o, 1'b0);
      chk("bp_data_hold", bus.res_data_o, 32'h0012_3456);
      step();
    end
    bus.res_ready_i = 1'b1;
    push(32'h0000_00F0, REQ_AUX);
    @(negedge clk);
    chk1("bp_release_ready1", bus.req1_ready_o, 1'b1);
    chk1("bp_release_busy", bus.busy_o, 1'b0);
    step();
    bus.req1_valid_i = 1'b0;
    @(negedge clk);
    chk("bp_new_data", bus.res_data_o, 32'h0000_00F0);
    chk1("bp_new_id", bus.res_id_o, 1'b1);
    chk1("bp_new_valid", bus.res_valid_o, 1'b1);

    // Amount masking (33 -> 1) then reserved op returning zero.
    step();
    bus.req1_valid_i = 1'b1;
    bus.req1_a_i     = 32'h0000_0001;
    bus.req1_b_i     = 32'd33;
    bus.req1_ope_i   = OP_SLL;
    push(32'h0000_0002, REQ_AUX);
    @(negedge clk);
    chk1("mask_ready1", bus.req1_ready_o, 1'b1);
    step();
    bus.req1_valid_i = 1'b0;
    bus.req0_valid_i = 1'b1;
    bus.req0_a_i     = 32'h0000_FFFF;
    bus.req0_b_i     = 32'd3;
    bus.req0_ope_i   = OP_RSV;
    push(32'h0000_0000, REQ_EX);
    @(negedge clk);
    chk("mask_data", bus.res_data_o, 32'h0000_0002);
    chk1("rsv_ready0", bus.req0_ready_o, 1'b1);
    step();
    bus.req0_valid_i = 1'b0;
    @(negedge clk);
    chk("rsv_data", bus.res_data_o, 32'h0000_0000);
    chk1("rsv_id", bus.res_id_o, 1'b0);
    chk1("rsv_valid", bus.res_valid_o, 1'b1);

    // Mid-operation reset: pending result dropped, pointer back to requester 0.
    step();
    bus.res_ready_i  = 1'b0;
    bus.req0_valid_i = 1'b1;
    bus.req0_a_i     = 32'h0000_0005;
    bus.req0_b_i     = 32'd1;
    bus.req0_ope_i   = OP_SLL;
    step();
    rst             = 1'b1;
    bus.res_ready_i = 1'b1;
    @(negedge clk);
    chk1("mrst_ready0", bus.req0_ready_o, 1'b0);
    chk1("mrst_ready1", bus.req1_ready_o, 1'b0);
    step();
    rst = 1'b0;
    bus.req1_valid_i = 1'b1;
    bus.req1_a_i     = 32'h0000_0001;
    bus.req1_b_i     = 32'd0;
    bus.req1_ope_i   = OP_SLL;
    push(32'h0000_000A, REQ_EX);
    @(negedge clk);
    chk1("mrst_valid", bus.res_valid_o, 1'b0);
    chk1("mrst_grant0", bus.req0_ready_o, 1'b1);
    chk1("mrst_no_grant1", bus.req1_ready_o, 1'b0);
    step();
    bus.req0_valid_i = 1'b0;
    push(32'h0000_0001, REQ_AUX);
    @(negedge clk);
    chk1("mrst_grant1", bus.req1_ready_o, 1'b1);
    step();
    bus.req1_valid_i = 1'b0;
    repeat (3) step();

    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one combinational barrel shifter (`shift`) between two requesters: req 0 = execute stage, req 1 = auxiliary unit (CSR/loader).
- Round-robin arbitration with a valid/ready handshake on each request port.
- Registered result with valid/ready backpressure and a requester tag.
- Sits between issue logic and writeback; turns the shared shifter into a 1-cycle-latency pipelined resource.

Parameters:
- N, 32, datapath width; power of 2, N >= 8
- SHW, $clog2(N), width of the effective shift amount

Ports:
- clk_i  in  1  clock, rising-edge
- rst_i  in  1  synchronous reset, active-high
- req0_valid_i  in  1  requester 0 has an operation
- req0_ready_o  out  1  requester 0 operation accepted this cycle
- req0_a_i  in  N  requester 0 operand (value to shift)
- req0_b_i  in  N  requester 0 shift amount
- req0_ope_i  in  2  requester 0 op: 00 SLL, 01 SRL, 10 SRA, 11 reserved
- req1_valid_i  in  1  requester 1 has an operation
- req1_ready_o  out  1  requester 1 operation accepted this cycle
- req1_a_i  in  N  requester 1 operand
- req1_b_i  in  N  requester 1 shift amount
- req1_ope_i  in  2  requester 1 op code
- res_valid_o  out  1  result register holds a valid result
- res_ready_i  in  1  consumer accepts the result
- res_data_o  out  N  shift result
- res_id_o  out  1  requester that produced res_data_o
- busy_o  out  1  result held, waiting for the consumer

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i.
- Reset values: res_valid_o=0, res_data_o=0, res_id_o=0, busy_o=0, rr_ptr=0 (requester 0 has priority first).
- Accept condition: can_accept = !res_valid_o | res_ready_i. Output register is freed on the same cycle the consumer takes the result (full throughput, 1 result per cycle).
- Grant, combinational, only when can_accept=1:
  - exactly one valid: that requester is granted;
  - both valid: grant the requester indicated by rr_ptr;
  - none valid: no grant.
- reqX_ready_o = grant to X. A ready never asserts while can_accept=0. Requesters must hold a/b/ope stable while valid and not ready.
- Operand path:
  - the granted requester's a and ope drive the shifter;
  - b is zero-extended from its low SHW bits (RISC-V shamt semantics). Example: b=33 with N=32 shifts by 1.
- ope=11 produces res_data_o = 0. It is still granted and still returns a result with its tag.
- On a grant edge:
  - res_data_o ← shifter output;
  - res_id_o ← granted id;
  - res_valid_o ← 1;
  - rr_ptr ← ~granted id.
- Consumption without a new grant: if res_valid_o & res_ready_i, res_valid_o ← 0. res_data_o and res_id_o keep their old values (don't-care).
- Simultaneous consume and grant: the new result overwrites the old one and res_valid_o stays 1.
- Latency: request accepted at edge k → result visible after edge k. A result is never dropped or duplicated.
- busy_o = res_valid_o & !res_ready_i.
- Fairness: with both requesters continuously valid and res_ready_i=1, grants alternate 0,1,0,1…
- Reset mid-operation: a pending result is discarded and no ready is asserted in the reset cycle (rst_i masks grants).
- States (implicit in res_valid_o):
  - EMPTY → FULL on grant;
  - FULL → FULL on grant while consuming, or when stalled;
  - FULL → EMPTY on consume with no grant.

Decomposition:
- Shared package `shift_pkg`:
  - op-code constants OP_SLL=2'b00, OP_SRL=2'b01, OP_SRA=2'b10, OP_RSV=2'b11;
  - requester id constants REQ_EX=1'b0, REQ_AUX=1'b1.
- Sub-module: one instance of the existing `shift` unit (parameter N passed through) for the datapath.
- Round-robin grant logic is small and stays inline. No separate arbiter module.

Test Plan:
- Reset then single request: req0 a=0x0000_00F0, b=4, ope=00, res_ready=1 → ready0 high for 1 cycle; next cycle res_valid=1, res_data=0x0000_0F00, res_id=0.
- Both valid, continuous, res_ready=1: req0 (0x8000_0000, b=31, SRA) and req1 (0x8000_0000, b=31, SRL) → grants alternate 0,1,0,…; results alternate 0xFFFF_FFFF(id0) and 0x0000_0001(id1).
- Backpressure: res_ready=0 for 3 cycles with req1 valid → res_valid=1, busy=1, ready0 and ready1 stay 0, res_data stable; raise res_ready → same-cycle grant of req1, new result next cycle, no loss.
- Amount masking and reserved op: req1 a=0x1, b=33, SLL → res_data=0x2; req0 ope=11 → res_data=0, res_id=0, res_valid=1.
- Mid-operation reset: result pending with res_ready=0, assert rst_i one cycle while req0 valid → res_valid=0, ready0=0 in that cycle, rr_ptr=0 after reset; with both valid on the first post-reset cycle, req0 is granted.
